// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared constants, FSM encoding and GF(2^8) helpers for the
//               iterative AES-256 cipher core.
// Revision    : 1.0
// ============================================================================
package aes_pkg;

    localparam int AES_NUM_ROUNDS = 14;
    localparam int AES_NUM_RKEYS  = AES_NUM_ROUNDS + 1;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_READY  = 2'd1,
        ST_ROUND  = 2'd2,
        ST_OUTPUT = 2'd3
    } aes_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bits [31:24] hold row 0.
    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    function automatic int shift_src(input int i);
        int r;
        int c;
        r = i % 4;
        c = i / 4;
        return r + 4 * ((c + r) % 4);
    endfunction

    function automatic int byte_msb(input int i);
        return 127 - 8 * i;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes256_cipher_core_if.sv
`default_nettype none
// ============================================================================
// Module      : aes256_cipher_core_if
// Description : Round-key load, block input and ciphertext output handshakes.
// Revision    : 1.0
// ============================================================================
interface aes256_cipher_core_if;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic         rk_ready;
    logic         rekey;
    logic         key_loaded;
    logic         in_valid;
    logic [127:0] in_block;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_block;
    logic         out_ready;
    logic         busy;

    modport slave (
        input  rk_valid, rk_data, rekey, in_valid, in_block, out_ready,
        output rk_ready, key_loaded, in_ready, out_valid, out_block, busy
    );

    modport master (
        output rk_valid, rk_data, rekey, in_valid, in_block, out_ready,
        input  rk_ready, key_loaded, in_ready, out_valid, out_block, busy
    );
endinterface
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational AES forward S-box (one byte).
// Revision    : 1.0
// ============================================================================
module aes_sbox (
    input  wire  [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [7:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_byte = SBOX_TABLE[i_byte];

endmodule
`default_nettype wire

// File: rtl/aes256_cipher_core.sv
`default_nettype none
// ============================================================================
// Module      : aes256_cipher_core
// Description : Iterative AES-256 encryption, one round per clock, with a
//               local 15-entry round-key store. Optional AES_ZEROIZE_EN
//               clears keys/state on entry to LOAD and masks idle output.
// Revision    : 1.0
// ============================================================================
module aes256_cipher_core
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  wire                       clk,
    input  wire                       rst,
    aes256_cipher_core_if.slave       bus
);

    localparam int         NRK      = NUM_ROUNDS + 1;
    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    aes_state_e   r_fsm;
    logic [3:0]   r_idx;
    logic [3:0]   r_rnd;
    logic         r_pending;
    logic         r_key_loaded;
    logic [127:0] r_blk;
    logic [127:0] r_store [NRK];

    logic [127:0] w_sub;
    logic [127:0] w_shift;
    logic [127:0] w_mix;
    logic [127:0] w_rk_cur;
    logic [127:0] w_round;
    logic         w_rk_we;
    logic         w_enter_load;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
            localparam int MSB = byte_msb(gi);
            localparam int SRC = byte_msb(shift_src(gi));
            aes_sbox u_sbox (
                .i_byte (r_blk[MSB -: 8]),
                .o_byte (w_sub[MSB -: 8])
            );
            assign w_shift[MSB -: 8] = w_sub[SRC -: 8];
        end
        for (genvar gc = 0; gc < 4; gc++) begin : g_mix
            assign w_mix[127 - 32*gc -: 32] = mix_column(w_shift[127 - 32*gc -: 32]);
        end
    endgenerate

    assign w_rk_cur = r_store[r_rnd];
    assign w_round  = ((r_rnd == LAST_IDX) ? w_shift : w_mix) ^ w_rk_cur;

    // A rekey coinciding with a key write wins: the load restarts at index 0.
    assign w_rk_we      = (r_fsm == ST_LOAD) && bus.rk_valid && !bus.rekey;
    assign w_enter_load = ((r_fsm == ST_READY) && bus.rekey && !bus.in_valid) ||
                          ((r_fsm == ST_OUTPUT) && bus.out_ready && (r_pending || bus.rekey));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm        <= ST_LOAD;
            r_idx        <= 4'd0;
            r_rnd        <= 4'd0;
            r_pending    <= 1'b0;
            r_key_loaded <= 1'b0;
            r_blk        <= '0;
        end else begin
            case (r_fsm)
                ST_LOAD: begin
                    if (bus.rekey) begin
                        r_idx <= 4'd0;
                    end else if (bus.rk_valid) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx        <= 4'd0;
                            r_key_loaded <= 1'b1;
                            r_fsm        <= ST_READY;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                ST_READY: begin
                    if (bus.in_valid) begin
                        r_blk     <= bus.in_block ^ r_store[0];
                        r_rnd     <= 4'd1;
                        r_pending <= bus.rekey;
                        r_fsm     <= ST_ROUND;
                    end else if (bus.rekey) begin
                        r_fsm <= ST_LOAD;
                    end
                end
                ST_ROUND: begin
                    r_blk <= w_round;
                    if (bus.rekey) begin
                        r_pending <= 1'b1;
                    end
                    if (r_rnd == LAST_IDX) begin
                        r_rnd <= 4'd0;
                        r_fsm <= ST_OUTPUT;
                    end else begin
                        r_rnd <= r_rnd + 4'd1;
                    end
                end
                ST_OUTPUT: begin
                    if (bus.rekey) begin
                        r_pending <= 1'b1;
                    end
                    if (bus.out_ready) begin
                        r_fsm <= (r_pending || bus.rekey) ? ST_LOAD : ST_READY;
                    end
                end
                default: r_fsm <= ST_LOAD;
            endcase

            if (w_enter_load) begin
                r_key_loaded <= 1'b0;
                r_idx        <= 4'd0;
                r_pending    <= 1'b0;
`ifdef AES_ZEROIZE_EN
                r_blk        <= '0;
`endif
            end
        end
    end

    // The key store is deliberately left out of reset.
    always_ff @(posedge clk) begin
`ifdef AES_ZEROIZE_EN
        if (w_enter_load) begin
            for (int k = 0; k < NRK; k++) begin
                r_store[k] <= '0;
            end
        end else if (w_rk_we) begin
            r_store[r_idx] <= bus.rk_data;
        end
`else
        if (w_rk_we) begin
            r_store[r_idx] <= bus.rk_data;
        end
`endif
    end

    assign bus.rk_ready   = (r_fsm == ST_LOAD);
    assign bus.in_ready   = (r_fsm == ST_READY);
    assign bus.out_valid  = (r_fsm == ST_OUTPUT);
    assign bus.busy       = (r_fsm == ST_ROUND) || (r_fsm == ST_OUTPUT);
    assign bus.key_loaded = r_key_loaded;
`ifdef AES_ZEROIZE_EN
    assign bus.out_block  = (r_fsm == ST_OUTPUT) ? r_blk : '0;
`else
    assign bus.out_block  = r_blk;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes256_cipher_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes256_cipher_core
// Description : Scoreboard bench for aes256_cipher_core with a byte-matrix
//               AES-256 reference model and FIPS-197 C.3 vector.
// Revision    : 1.0
// ============================================================================
module tb_aes256_cipher_core;

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes256_cipher_core_if bus ();

    aes256_cipher_core #(.NUM_ROUNDS(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int           checks = 0;
    int           errors = 0;
    int           cycle  = 0;
    logic [127:0] exp_q [$];
    int           lat_q [$];
    logic [127:0] last_out   = '0;
    logic         prev_ov    = 1'b0;
    logic         rand_ready = 1'b0;
    logic [7:0]   tb_sbox [256];
    logic [127:0] model_rk [15];

    always @(posedge clk) cycle++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv = 8'h01;
            logic [7:0] b   = 8'(v);
            if (v == 0) inv = 8'h00;
            else for (int k = 0; k < 254; k++) inv = gmul(inv, b);
            tb_sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = subword(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int r = 0; r < 15; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [7:0] mc_coef(input int d);
        case (d)
            0: return 8'h02;
            1: return 8'h03;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] blk;
        blk = pt ^ model_rk[0];
        for (int r = 1; r <= 14; r++) begin
            for (int i = 0; i < 16; i++) s[i % 4][i / 4] = tb_sbox[blk[127 - 8*i -: 8]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++) t[row][col] = s[row][(col + row) % 4];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++) begin
                    if (r == 14) s[row][col] = t[row][col];
                    else begin
                        s[row][col] = 8'h00;
                        for (int k = 0; k < 4; k++)
                            s[row][col] = s[row][col] ^ gmul(mc_coef((k - row + 4) % 4), t[k][col]);
                    end
                end
            for (int i = 0; i < 16; i++) blk[127 - 8*i -: 8] = s[i % 4][i / 4];
            blk = blk ^ model_rk[r];
        end
        return blk;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (bus.out_valid && !prev_ov) begin
                if (lat_q.size() == 0) fail_timeout("latency_no_accept");
                else chk("latency", 128'(cycle - lat_q.pop_front()), 128'd14);
            end
            prev_ov = bus.out_valid;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_output", 128'd1, 128'd0);
                else chk("ciphertext", bus.out_block, exp_q.pop_front());
                last_out = bus.out_block;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- stimulus tasks (entered just after a rising edge) ----------------
    task automatic load_keys(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            int n = 0;
            bus.rk_valid = 1'b1;
            bus.rk_data  = model_rk[k];
            do begin
                @(negedge clk);
                n++;
            end while (!bus.rk_ready && n < 100);
            if (!bus.rk_ready) fail_timeout("rk_handshake");
            @(posedge clk);
            #1;
        end
        bus.rk_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] pt, output int waited);
        bus.in_valid = 1'b1;
        bus.in_block = pt;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 300) break;
        end
        if (bus.in_ready) begin
            exp_q.push_back(model_encrypt(pt));
            lat_q.push_back(cycle + 1);
        end else begin
            fail_timeout("in_handshake");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 100);
        if (!bus.out_valid) fail_timeout("out_valid");
    endtask

    task automatic do_rekey();
        bus.rekey = 1'b1;
        @(posedge clk);
        #1;
        bus.rekey = 1'b0;
        @(negedge clk);
        chk("rekey_key_loaded", bus.key_loaded, 1'b0);
        chk("rekey_rk_ready", bus.rk_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rk_ready"}, bus.rk_ready, 1'b1);
        chk({tag, "_key_loaded"}, bus.key_loaded, 1'b0);
        chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
        chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_out_block"}, bus.out_block, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        rst           = 1'b1;
        bus.rk_valid  = 1'b0;
        bus.rk_data   = '0;
        bus.rekey     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.out_ready = 1'b1;
        build_sbox();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Blocks offered before the key load completes must wait.
        expand_key(C3_KEY);
        load_keys(0, 6);
        bus.in_valid = 1'b1;
        bus.in_block = C3_PT;
        repeat (4) begin
            @(negedge clk);
            chk("preload_in_ready", bus.in_ready, 1'b0);
            chk("preload_out_valid", bus.out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        load_keys(7, 14);
        send_block(C3_PT, waited);
        chk("accept_after_load", 128'(waited), 128'd0);
        chk("key_loaded", bus.key_loaded, 1'b1);
        wait_out();
        @(posedge clk);
        #1;
        chk("c3_vector", last_out, C3_CT);

        // Backpressure: output held, then an identical block right after.
        bus.out_ready = 1'b0;
        send_block(C3_PT, waited);
        wait_out();
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_block", bus.out_block, C3_CT);
            chk("bp_out_valid", bus.out_valid, 1'b1);
            chk("bp_in_ready", bus.in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send_block(C3_PT, waited);
        chk("bp_second_accept", 128'(waited), 128'd1);
        wait_out();
        @(posedge clk);
        #1;
        chk("bp_second_ct", last_out, C3_CT);

        // Random keys and blocks with random output backpressure.
        for (int kk = 0; kk < 3; kk++) begin
            int n = 0;
            do_rekey();
            expand_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            load_keys(0, 14);
            rand_ready = 1'b1;
            for (int b = 0; b < 4; b++) begin
                send_block({$urandom, $urandom, $urandom, $urandom}, waited);
            end
            while (exp_q.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (exp_q.size() != 0) fail_timeout("drain");
            rand_ready = 1'b0;
            @(posedge clk);
            #2;
            bus.out_ready = 1'b1;
        end

        // Rekey during round 5: block completes with old keys, then LOAD.
        #0;
        do_rekey();
        expand_key(C3_KEY);
        load_keys(0, 14);
        send_block(C3_PT, waited);
        repeat (4) @(posedge clk);
        #1;
        bus.rekey = 1'b1;
        @(posedge clk);
        #1;
        bus.rekey = 1'b0;
        wait_out();
        @(posedge clk);
        #1;
        chk("inflight_ct", last_out, C3_CT);
        @(negedge clk);
        chk("inflight_key_loaded", bus.key_loaded, 1'b0);
        chk("inflight_rk_ready", bus.rk_ready, 1'b1);
        chk("inflight_busy", bus.busy, 1'b0);
`ifdef AES_ZEROIZE_EN
        chk("idle_out_block_zero", bus.out_block, 128'd0);
`else
        chk("idle_out_block_held", bus.out_block, C3_CT);
`endif
        @(posedge clk);
        #1;

        // Asynchronous reset mid-cycle with a block in flight.
        load_keys(0, 14);
        send_block({$urandom, $urandom, $urandom, $urandom}, waited);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        lat_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes256_cipher_core.md
# aes256_cipher_core

Iterative AES-256 encryption datapath. It sits directly downstream of the key expansion stage and consumes its stream of 15 round keys into a local round-key store. It then encrypts 128-bit counter blocks for the CTR keystream, one round per clock, and can encrypt any number of blocks per key load.

## Interface
- `NUM_ROUNDS`, default 14: cipher rounds; round keys stored = NUM_ROUNDS+1. Only 14 is supported.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `rk_valid` in 1: a round key is offered.
- `rk_data` in 128: round key, supplied in order 0..14.
- `rk_ready` out 1: core accepts round keys (LOAD state).
- `rekey` in 1: single-cycle request to discard the stored keys and reload.
- `key_loaded` out 1: all 15 round keys are stored.
- `in_valid` in 1: input block offered.
- `in_block` in 128: plaintext/counter block.
- `in_ready` out 1: core accepts a block.
- `out_valid` out 1: ciphertext available.
- `out_block` out 128: ciphertext.
- `out_ready` in 1: consumer accepts ciphertext.
- `busy` out 1: a block is in flight (ROUND or OUTPUT).

## Operation
- Byte order follows FIPS-197 column-major. Bits [127:120] are byte 0 (row 0, col 0). The same order applies to `rk_data`.
- States: LOAD, READY, ROUND, OUTPUT.
- LOAD:
  - `rk_ready`=1.
  - Each `rk_valid`&`rk_ready` edge writes `rk_data` to store[idx], then idx++. idx is 4 bits, 0..14.
  - On the idx=14 write: `key_loaded`<=1, idx<=0, go to READY.
- READY:
  - `in_ready`=1.
  - On an `in_valid` handshake: state <= `in_block` ^ store[0], rnd<=1, go to ROUND.
  - `rk_valid` is ignored.
- ROUND, one round per cycle:
  - rnd 1..13: SubBytes, ShiftRows, MixColumns, AddRoundKey(store[rnd]).
  - rnd 14: SubBytes, ShiftRows, AddRoundKey(store[14]), then go to OUTPUT.
- OUTPUT:
  - `out_valid`=1 and `out_block`=state, both held stable until the `out_ready` handshake.
  - After the handshake, go to READY, or to LOAD if a rekey is pending.
- MixColumns uses GF(2^8) with polynomial 0x11b. xtime(b) = (b<<1) ^ (b[7] ? 0x1b : 0).
- Rekey:
  - In READY with no simultaneous `in_valid` handshake, `rekey` forces LOAD, `key_loaded`<=0, idx<=0.
  - If `rekey` and an `in_valid` handshake occur in the same READY cycle, the block is accepted and the rekey is pending.
  - In ROUND or OUTPUT, `rekey` sets a pending flag. The block in flight completes with the old keys, then the core enters LOAD.
  - In LOAD, `rekey` restarts idx at 0.
- `in_ready` is 0 in LOAD, ROUND and OUTPUT. A block never enters before `key_loaded`.

## Timing
- Reset values:
  - state=LOAD, so `rk_ready`=1.
  - `key_loaded`=0, `in_ready`=0, `out_valid`=0, `busy`=0.
  - `out_block`=0, idx=0, rnd=0, pending=0.
  - The round-key store is not reset.
- Accept-to-`out_valid` latency is exactly 14 cycles: handshake at edge E, `out_valid` high after edge E+14.
- Maximum throughput is one block per 16 cycles, with `out_ready` held high and `in_valid` held high.
- Key load takes 15 handshake cycles minimum. `in_ready` rises on the cycle after the 15th key handshake.
- An asynchronous reset during any state returns every output to its reset value immediately. The in-flight block is lost.

## Configuration
- `AES_ZEROIZE_EN` defined:
  - Entering LOAD (reset excluded) clears all 15 stored round keys and the state register to zero in that same cycle.
  - `out_block` is forced to 0 whenever `out_valid`=0.
- `AES_ZEROIZE_EN` undefined:
  - Stored keys persist until overwritten.
  - `out_block` holds the last state value.

## Structure
- Package `aes_pkg` holds:
  - `NUM_ROUNDS` and the round-key count.
  - The state enum: LOAD, READY, ROUND, OUTPUT.
  - The `xtime` and `mix_column` functions.
  - The byte-index helpers for ShiftRows.
- Sub-module `aes_sbox` is a combinational 8-bit forward S-box, instantiated 16 times.

## Test plan
- Reset check. Assert `rst` mid-cycle → asynchronously: `rk_ready`=1, `key_loaded`=0, `out_valid`=0, `busy`=0, `out_block`=0.
- FIPS-197 C.3 vector:
  - Load the expansion of key 000102…1f; rk0=000102…0f, rk1=101112…1f.
  - Encrypt 00112233445566778899aabbccddeeff → `out_block`=8ea2b7ca516745bfeafc49904b496089.
  - `out_valid` rises exactly 14 cycles after accept.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles → `out_block` stable, `in_ready`=0.
  - Then a second, identical block is accepted 1 cycle after the output handshake → identical ciphertext.
- Blocks before key load:
  - `in_valid`=1 while only 7 keys are loaded → `in_ready` stays 0, no output.
  - Finish the load → the block is accepted on the next cycle.
- Rekey in flight:
  - Pulse `rekey` at rnd=5 → the C.3 ciphertext is still produced.
  - After the `out_ready` handshake: `key_loaded`=0, `rk_ready`=1.
- Zeroize (`AES_ZEROIZE_EN`):
  - After a rekey, the store reads all-zero.
  - With no new keys loaded, `out_block`=0 while idle.
